// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 is treated as word)
//   - controller state codes
//   - lane_extract: pull a byte/half/word out of a memory word and extend it
//   - lane_merge:   replace the addressed byte/half lane of a memory word
// Lanes are little-endian: byte lane = offset[1:0], half lane = offset[1].
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_LD_EXT = 3'd2;
    localparam logic [2:0] ST_RMW_WR = 3'd3;
    localparam logic [2:0] ST_WR     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] rdata,
        input logic [1:0]  offset,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{offset, 3'b000} +: 8];
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
            SZ_HALF: r = {{16{~is_unsigned & h[15]}}, h};
            default: r = rdata;  // word loads are never extended
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  offset,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_BYTE: r[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1]) r[31:16] = wdata[15:0];
                else           r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane steering shared by the load-extend and
// read-modify-write paths of lsu_ctrl.
// Ports:
//   rdata       in  32  memory word just read
//   wdata       in  32  right-aligned store data
//   offset      in  2   byte offset inside the word (already aligned to size)
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   load_data   out 32  extracted and extended load result
//   merge_data  out 32  rdata with the addressed lane replaced by wdata
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    assign load_data  = lane_extract(rdata, offset, size, is_unsigned);
    assign merge_data = lane_merge(rdata, wdata, offset, size);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the CPU MEM stage and a word-wide
// data memory. Byte/half/word loads with sign/zero extension; sub-word stores
// are done as read-modify-write because the memory only writes full words.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses go to TRAP, no memory strobe,
//               and respond with resp_err=1, resp_rdata=0
//   undefined - offending low address bits are forced to zero; resp_err is 0
//
// Parameter: MEM_AW - log2 of memory depth in words
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result (0 for stores), misalign trap flag
//   memread, memwrite     memory strobes (decoded from state)
//   mem_addr, mem_wdata   word index and full-word write data
//   mem_rdata             memory data, valid the cycle after memread
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1. req_ready is 1 exactly in IDLE, so the requester
    // must hold valid and all fields stable until then; valid while busy is
    // simply ignored. resp_valid pulses for one cycle, with no ready back.

    logic [2:0]        state;
    logic [MEM_AW-1:0] lat_widx;
    logic [1:0]        lat_off;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic              lat_write;
    logic [31:0]       lat_wdata;

    logic [1:0]        req_size_n;
    logic [1:0]        req_off_n;
    logic [2:0]        accept_state;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    // Address bits above the memory range wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

    always_comb begin
        // Reserved size 2'b11 behaves exactly like a word access.
        req_size_n   = (req_size == 2'b11) ? SZ_WORD : req_size;
        req_off_n    = 2'b00;
        accept_state = ST_RD;
`ifdef MISALIGN_TRAP_EN
        req_off_n = req_addr[1:0];
        if ((req_size_n == SZ_HALF && req_addr[0]) ||
            (req_size_n == SZ_WORD && req_addr[1:0] != 2'b00))
            accept_state = ST_TRAP;
        else if (req_write && req_size_n == SZ_WORD)
            accept_state = ST_WR;
        else
            accept_state = ST_RD;
`else
        case (req_size_n)
            SZ_BYTE: req_off_n = req_addr[1:0];
            SZ_HALF: req_off_n = {req_addr[1], 1'b0};
            default: req_off_n = 2'b00;
        endcase
        // Full-word stores need no read; everything else reads first.
        accept_state = (req_write && req_size_n == SZ_WORD) ? ST_WR : ST_RD;
`endif
    end

    lsu_lane u_lane (
        .rdata       (mem_rdata),
        .wdata       (lat_wdata),
        .offset      (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            lat_widx     <= '0;
            lat_off      <= 2'b00;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
            lat_wdata    <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_widx     <= req_addr[MEM_AW+1:2];
                        lat_off      <= req_off_n;
                        lat_size     <= req_size_n;
                        lat_unsigned <= req_unsigned;
                        lat_write    <= req_write;
                        lat_wdata    <= req_wdata;
                        state        <= accept_state;
                    end
                end
                ST_RD:     state <= lat_write ? ST_RMW_WR : ST_LD_EXT;
                ST_LD_EXT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                    state      <= ST_IDLE;
                end
                ST_RMW_WR, ST_WR: begin
                    resp_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
`ifdef MISALIGN_TRAP_EN
                ST_TRAP: begin
                    resp_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) resp_err <= 1'b0;
        else     resp_err <= (state == ST_TRAP);
    end
`else
    assign resp_err = 1'b0;
`endif

    // Memory-side outputs are pure decodes of state; mem_addr/mem_wdata are
    // held at zero whenever no strobe is active.
    always_comb begin
        req_ready = (state == ST_IDLE);
        memread   = (state == ST_RD);
        memwrite  = (state == ST_WR) || (state == ST_RMW_WR);
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (memread || memwrite)
            mem_addr = {{(32-MEM_AW){1'b0}}, lat_widx};
        if (state == ST_WR)
            mem_wdata = lat_wdata;
        else if (state == ST_RMW_WR)
            mem_wdata = merge_data;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed, table-driven bench for lsu_ctrl with a behavioural
// word memory (rdata registered on memread, write on memwrite).
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memread;
    logic        memwrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    logic [31:0] mem [0:1023];
    logic        mem_clear;

    lsu_ctrl #(.MEM_AW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .memread      (memread),
        .memwrite     (memwrite),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Clock and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            if (memread)  mem_rdata <= mem[mem_addr[9:0]];
            if (memwrite) mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request, wait for acceptance and response; report what was seen.
    task automatic do_req(
        input  logic        w,
        input  logic [1:0]  sz,
        input  logic        u,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        err,
        output int          lat,
        output int          nrd,
        output int          nwr,
        output logic [31:0] saddr,
        output logic        overlap
    );
        int   guard;
        logic got;
        rd = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; saddr = 32'h0; overlap = 1'b0;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 10) begin
            if (memread)  begin nrd++; saddr = mem_addr; end
            if (memwrite) begin nwr++; saddr = mem_addr; end
            if (memread && memwrite) overlap = 1'b1;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                err = resp_err;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check("resp_seen", {31'b0, got}, 32'h1);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [31:0] exp_maddr;
        logic        chk_mem;
        int          mem_idx;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input int el, input int enr, input int enw, input logic [31:0] ema,
                       input logic cm, input int mi, input logic [31:0] em);
        vec_t v;
        v.name = n; v.w = w; v.sz = sz; v.u = u; v.addr = a; v.wdata = wd;
        v.exp_rd = er; v.exp_lat = el; v.exp_nrd = enr; v.exp_nwr = enw;
        v.exp_maddr = ema; v.chk_mem = cm; v.mem_idx = mi; v.exp_mem = em;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, nrd, nwr;
        logic [31:0] saddr;
        logic        ovl;
        logic        found;
        logic        any_wr;

        tests = 0; fails = 0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        //   name        w  sz     u  addr          wdata         exp_rd        lat rd wr maddr   chk idx exp_mem
        add("sw_10",     1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 32'h0,        2, 0, 1, 32'h4,   1, 4,   32'hDEADBEEF);
        add("lb_13",     0, 2'b00, 0, 32'h13,       32'h0,        32'hFFFFFFDE, 3, 1, 0, 32'h4,   1, 4,   32'hDEADBEEF);
        add("lbu_13",    0, 2'b00, 1, 32'h13,       32'h0,        32'h000000DE, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("lh_10",     0, 2'b01, 0, 32'h10,       32'h0,        32'hFFFFBEEF, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("lhu_12",    0, 2'b01, 1, 32'h12,       32'h0,        32'h0000DEAD, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("lw_10",     0, 2'b10, 0, 32'h10,       32'h0,        32'hDEADBEEF, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("sb_11",     1, 2'b00, 0, 32'h11,       32'h000000AA, 32'h0,        3, 1, 1, 32'h4,   1, 4,   32'hDEADAAEF);
        add("lbu_11",    0, 2'b00, 1, 32'h11,       32'h0,        32'h000000AA, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("lb_11",     0, 2'b00, 0, 32'h11,       32'h0,        32'hFFFFFFAA, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("sh_22",     1, 2'b01, 0, 32'h22,       32'h12347FFF, 32'h0,        3, 1, 1, 32'h8,   1, 8,   32'h7FFF0000);
        add("lh_22",     0, 2'b01, 0, 32'h22,       32'h0,        32'h00007FFF, 3, 1, 0, 32'h8,   0, 8,   32'h0);
        add("lh_20",     0, 2'b01, 0, 32'h20,       32'h0,        32'h00000000, 3, 1, 0, 32'h8,   0, 8,   32'h0);
        add("sw_wrap",   1, 2'b10, 0, 32'h10000FFC, 32'h01020304, 32'h0,        2, 0, 1, 32'h3FF, 1, 1023, 32'h01020304);
        add("lw_ffc",    0, 2'b10, 0, 32'hFFC,      32'h0,        32'h01020304, 3, 1, 0, 32'h3FF, 0, 0,   32'h0);
        add("lres_10",   0, 2'b11, 1, 32'h10,       32'h0,        32'hDEADAAEF, 3, 1, 0, 32'h4,   0, 4,   32'h0);
        add("sres_24",   1, 2'b11, 0, 32'h24,       32'hCAFEF00D, 32'h0,        2, 0, 1, 32'h9,   1, 9,   32'hCAFEF00D);
        add("sb_10",     1, 2'b00, 0, 32'h10,       32'hFFFFFF80, 32'h0,        3, 1, 1, 32'h4,   1, 4,   32'hDEADAA80);
        add("lb_10",     0, 2'b00, 0, 32'h10,       32'h0,        32'hFFFFFF80, 3, 1, 0, 32'h4,   0, 4,   32'h0);

        // Reset block
        rst = 1'b1;
        mem_clear = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_clear = 1'b0;
        check("rst_req_ready",  {31'b0, req_ready},  32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_resp_err",   {31'b0, resp_err},   32'h0);
        check("rst_memread",    {31'b0, memread},    32'h0);
        check("rst_memwrite",   {31'b0, memwrite},   32'h0);
        check("rst_mem_addr",   mem_addr,            32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wdata,
                   rd, err, lat, nrd, nwr, saddr, ovl);
            check({vecs[i].name, "_rdata"},   rd, vecs[i].exp_rd);
            check({vecs[i].name, "_err"},     {31'b0, err}, 32'h0);
            check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, "_reads"},   nrd, vecs[i].exp_nrd);
            check({vecs[i].name, "_writes"},  nwr, vecs[i].exp_nwr);
            check({vecs[i].name, "_maddr"},   saddr, vecs[i].exp_maddr);
            check({vecs[i].name, "_overlap"}, {31'b0, ovl}, 32'h0);
            if (vecs[i].chk_mem)
                check({vecs[i].name, "_mem"}, mem[vecs[i].mem_idx], vecs[i].exp_mem);
        end

        // Back-to-back: second request held through the first, accepted on
        // the edge where the first response is visible.
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        check("b2b_ready1", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h12;
        found = 1'b0; ovl = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (memread && memwrite) ovl = 1'b1;
            if (resp_valid) begin
                found = 1'b1;
                check("b2b_rdata1", resp_rdata, 32'hDEADAA80);
                check("b2b_ready_with_resp", {31'b0, req_ready}, 32'h1);
            end else begin
                @(negedge clk);
            end
        end
        check("b2b_resp1_seen", {31'b0, found}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; found = 1'b0;
        while (!found && lat <= 10) begin
            if (memread && memwrite) ovl = 1'b1;
            if (resp_valid) begin
                found = 1'b1;
                check("b2b_rdata2", resp_rdata, 32'h000000AD);
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check("b2b_resp2_seen", {31'b0, found}, 32'h1);
        check("b2b_latency2", lat, 32'd3);
        check("b2b_overlap", {31'b0, ovl}, 32'h0);

        // Reset while in RD: the pending byte store must never write.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstrd_in_rd", {31'b0, memread}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstrd_memread",    {31'b0, memread},    32'h0);
        check("rstrd_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rstrd_req_ready",  {31'b0, req_ready},  32'h1);
        any_wr = memwrite;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            any_wr = any_wr | memwrite | resp_valid;
        end
        check("rstrd_no_write", {31'b0, any_wr}, 32'h0);
        check("rstrd_mem", mem[4], 32'hDEADAA80);

        // Misaligned half load at 0x11
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, err, lat, nrd, nwr, saddr, ovl);
`ifdef MISALIGN_TRAP_EN
        check("mis_rdata",   rd, 32'h0);
        check("mis_err",     {31'b0, err}, 32'h1);
        check("mis_latency", lat, 32'd2);
        check("mis_strobes", nrd + nwr, 32'd0);
`else
        check("mis_rdata",   rd, 32'hFFFFAA80);
        check("mis_err",     {31'b0, err}, 32'h0);
        check("mis_latency", lat, 32'd3);
        check("mis_reads",   nrd, 32'd1);
        check("mis_maddr",   saddr, 32'h4);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
